// File: rtl/gray_ptr_sync.sv
// Gray-coded pointer engine for one side of an asynchronous FIFO.
// Keeps the local binary/Gray pointer pair, synchronises and decodes the
// remote Gray pointer, and produces a registered level plus full/empty flag.
//
// Parameters:
//   WIDTH         pointer width including wrap bit (depth = 2^(WIDTH-1)), 2..16
//   SYNC_STAGES   synchroniser depth on rmt_gray_i, 2..4
//   MODE          0 = write side (flag_o = full), 1 = read side (flag_o = empty)
//   ALMOST_THRESH almost threshold, present only with GRAY_PTR_ALMOST_EN
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   inc_i          advance local pointer request
//   ptr_bin_o      local binary pointer
//   ptr_gray_o     Gray code of ptr_bin_o, for the remote domain
//   addr_o         RAM address (pointer without wrap bit)
//   rmt_gray_i     remote Gray pointer, asynchronous to clk_i
//   rmt_bin_o      synchronised, decoded remote pointer
//   level_o        occupancy (MODE 0) or available entries (MODE 1)
//   flag_o         full (MODE 0) or empty (MODE 1)
//   err_o          one-cycle pulse when an increment is refused
//   almost_o       almost-full / almost-empty (only with GRAY_PTR_ALMOST_EN)
module gray_ptr_sync #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MODE        = 0
`ifdef GRAY_PTR_ALMOST_EN
  , parameter int unsigned ALMOST_THRESH = 2
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] ptr_bin_o,
  output logic [WIDTH-1:0] ptr_gray_o,
  output logic [WIDTH-2:0] addr_o,
  input  logic [WIDTH-1:0] rmt_gray_i,
  output logic [WIDTH-1:0] rmt_bin_o,
  output logic [WIDTH-1:0] level_o,
  output logic             flag_o,
  output logic             err_o
`ifdef GRAY_PTR_ALMOST_EN
  , output logic           almost_o
`endif
);

  // Level value that means "full" on the write side (FIFO depth).
  localparam logic [WIDTH-1:0] HALF     = {1'b1, {(WIDTH-1){1'b0}}};
  // Read side starts empty, write side starts not-full.
  localparam logic             FLAG_RST = (MODE == 32'd1);

  logic [WIDTH-1:0] ptr_bin_q,  ptr_bin_d;
  logic [WIDTH-1:0] ptr_gray_q, ptr_gray_d;
  logic [WIDTH-1:0] rmt_bin_q,  rmt_bin_d;
  logic [WIDTH-1:0] level_q,    level_d;
  logic             flag_q,     flag_d;
  logic             err_q,      err_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic             accept;
`ifdef GRAY_PTR_ALMOST_EN
  logic             almost_q,   almost_d;
`endif

  // Next-state: pointer advance, remote decode, level and flags.
  always_comb begin
    accept     = inc_i & ~flag_q;
    ptr_bin_d  = ptr_bin_q + WIDTH'(accept);
    ptr_gray_d = ptr_bin_d ^ (ptr_bin_d >> 1);
    err_d      = inc_i & flag_q;

    // Gray decode: bit i is the XOR of Gray bits i..MSB.
    rmt_bin_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      rmt_bin_d[i] = ^(sync_q[SYNC_STAGES-1] >> i);
    end

    // Level uses the post-increment local pointer so flags are pessimistic.
    if (MODE == 32'd0) begin
      level_d = ptr_bin_d - rmt_bin_q;
      flag_d  = (level_d == HALF);
    end else begin
      level_d = rmt_bin_q - ptr_bin_d;
      flag_d  = (level_d == '0);
    end

`ifdef GRAY_PTR_ALMOST_EN
    if (MODE == 32'd0) begin
      almost_d = (level_d >= (HALF - WIDTH'(ALMOST_THRESH)));
    end else begin
      almost_d = (level_d <= WIDTH'(ALMOST_THRESH));
    end
`endif
  end

  // State registers and remote-pointer synchroniser.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_bin_q  <= '0;
      ptr_gray_q <= '0;
      rmt_bin_q  <= '0;
      level_q    <= '0;
      flag_q     <= FLAG_RST;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
`ifdef GRAY_PTR_ALMOST_EN
      almost_q   <= FLAG_RST;
`endif
    end else begin
      ptr_bin_q  <= ptr_bin_d;
      ptr_gray_q <= ptr_gray_d;
      rmt_bin_q  <= rmt_bin_d;
      level_q    <= level_d;
      flag_q     <= flag_d;
      err_q      <= err_d;
      sync_q[0]  <= rmt_gray_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
`ifdef GRAY_PTR_ALMOST_EN
      almost_q   <= almost_d;
`endif
    end
  end

  assign ptr_bin_o  = ptr_bin_q;
  assign ptr_gray_o = ptr_gray_q;
  assign addr_o     = ptr_bin_q[WIDTH-2:0];
  assign rmt_bin_o  = rmt_bin_q;
  assign level_o    = level_q;
  assign flag_o     = flag_q;
  assign err_o      = err_q;
`ifdef GRAY_PTR_ALMOST_EN
  assign almost_o   = almost_q;
`endif

endmodule
